pwm_duty_meas: RTL
==================

Name: pwm_duty_meas

Overview:
Receive-side counterpart to the PWM generator. Samples an external PWM waveform and measures its period and high time in clk cycles. Converts the ratio into a DUTY_W-bit duty code with a multi-cycle sequential divider, so a generator driven with code N reads back as approximately N. Sits on the input side of the PWM path, or in loopback benches for generator checking.

Parameters:
DUTY_W, 4, width of the duty code output.
CNT_W, 16, width of the period/high counters; sets the timeout at 2^CNT_W-1 cycles.
SYNC_STAGES, 2, number of input synchroniser flops (minimum 2).

Ports:
clk  in  1  system clock.
rst  in  1  reset, synchronous, active-high.
pwm_in  in  1  asynchronous PWM input.
duty_out  out  DUTY_W  last computed duty code; held between updates.
duty_valid  out  1  one-cycle pulse when duty_out updates.
period_cnt  out  CNT_W  last measured period in clk cycles.
high_cnt  out  CNT_W  last measured high time in clk cycles.
timeout  out  1  one-cycle pulse when no rising edge is seen for 2^CNT_W-1 cycles.
overrun  out  1  one-cycle pulse when a period completes while the divider is busy.

Behaviour:
- Single clock domain; rst is synchronous, active-high.
- On rst: synchroniser flops, edge flop, counters and all outputs = 0; FSM = IDLE.
- Input conditioning: pwm_in passes through SYNC_STAGES flops to give s. A rising edge is flagged when s=1 and the previous s=0. Edge detection adds SYNC_STAGES+1 cycles of fixed latency, with no glitch filtering.
- FSM states: IDLE, MEAS, DIV.
  - IDLE: wait for the first rising edge. On that edge, clear p_cnt to 1 and h_cnt to 1, then go to MEAS.
  - MEAS: each cycle, p_cnt += 1 and h_cnt += s.
  - On the next rising edge:
    - latch P=p_cnt and H=h_cnt into period_cnt/high_cnt;
    - restart p_cnt=1 and h_cnt=1;
    - go to DIV.
  - DIV: the divider runs while measurement of the next period continues. The divider is restoring, DUTY_W iterations, one per cycle:
    - r starts at H;
    - each step: r = 2r; if r >= P then q-bit = 1 and r -= P.
    - Result is floor(H*2^DUTY_W/P). Internal r width is CNT_W+1.
  - After the last iteration: duty_out = q, duty_valid = 1 for one cycle, return to MEAS.
- Latency: duty_valid rises exactly DUTY_W+1 cycles after the cycle the closing rising edge is flagged.
- Saturation: H <= P-1 by construction. If q would exceed 2^DUTY_W-1, force all ones.
- Overrun: a rising edge during DIV closes a period that is not reported.
  - overrun pulses and period_cnt/high_cnt are not updated.
  - The counters still restart, and the divider completes with the original H/P.
  - Minimum reportable period is DUTY_W+1 cycles.
- Timeout: if p_cnt reaches 2^CNT_W-1 in MEAS or DIV:
  - any in-flight division is abandoned;
  - timeout pulses and the FSM goes to IDLE;
  - duty_out = all ones if s=1, else 0;
  - duty_valid pulses in the same cycle; period_cnt/high_cnt = 0.
  - In IDLE, the timeout counter runs the same way, so a stuck level re-reports every 2^CNT_W-1 cycles.
- Simultaneous edge and timeout in the same cycle: the edge wins and the counter restarts.
- rst mid-operation aborts everything. No duty_valid follows until two new rising edges have been seen.

Decomposition:
- Package pwm_pkg holds:
  - the state enum {IDLE, MEAS, DIV};
  - the divider iteration count = DUTY_W;
  - the timeout constant = {CNT_W{1'b1}}.
- One sub-module: pwm_div_seq, the restoring divider. It has a start/busy/done handshake, inputs H and P, output q, and takes DUTY_W cycles from start to done.
- Synchroniser and counters stay inline.

Test Plan:
1. Period 16, high 4, repeated, DUTY_W=4 -> every period: period_cnt=16, high_cnt=4, duty_out=4, duty_valid exactly 5 cycles after the edge flag.
2. Period 16 high 15 -> duty_out=15. Period 32 high 1 -> duty_out=0 (floor). Period 20 high 10 -> duty_out=8.
3. CNT_W=8; hold pwm_in=0 for 600 cycles -> timeout and duty_valid pulse every 255 cycles, duty_out=0. Repeat with pwm_in=1 -> duty_out=15.
4. Period 3 high 1 -> overrun pulses on alternate edges, duty_out=5 (floor(1*16/3)), no duty_valid for dropped periods.
5. Assert rst during DIV -> all outputs 0 the next cycle, no duty_valid. After release, first duty_valid only after the second rising edge.
6. Loopback with the team's PWM generator, sweep codes 0..15 -> measured duty_out within ±1 of the expected generator duty for each code, no overrun or timeout.

Source files
------------

// File: rtl/pwm_duty_meas_pkg.sv
// Shared types and constants for the PWM duty-cycle measurement block.
package pwm_pkg;

  // Measurement FSM states: waiting for a first edge, counting, dividing.
  typedef enum logic [1:0] {
    IDLE,
    MEAS,
    DIV
  } meas_state_t;

  localparam int DEF_DUTY_W = 4;
  localparam int DEF_CNT_W  = 16;

  // The restoring divider produces one quotient bit per iteration.
  function automatic int div_iters(input int duty_w);
    return duty_w;
  endfunction

  // Counter value at which a missing rising edge is declared a timeout
  // (all ones of the counter width; handles widths up to 32).
  function automatic logic [31:0] timeout_count(input int cnt_w);
    logic [32:0] one_shifted;
    one_shifted = 33'd1 << cnt_w;
    return 32'(one_shifted - 33'd1);
  endfunction

endpackage

// File: rtl/pwm_duty_meas_div_seq.sv
// Restoring divider: q = floor(h * 2^DUTY_W / p), one bit per cycle.
// done and q are presented combinationally during the last iteration so the
// caller can register the result on the same edge the divider goes idle.
module pwm_div_seq
  import pwm_pkg::*;
#(
  parameter int DUTY_W = DEF_DUTY_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  h,
  input  logic [CNT_W-1:0]  p,
  output logic              busy,
  output logic              done,
  output logic [DUTY_W-1:0] q
);

  localparam int ITERS = div_iters(DUTY_W);
  localparam int IW    = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [IW-1:0] LAST = IW'(ITERS - 1);

  logic [CNT_W:0]    rem_q;
  logic [CNT_W-1:0]  div_q;
  logic [DUTY_W-1:0] quo_q;
  logic [IW-1:0]     iter_q;
  logic              busy_q;
  logic              sat_q;

  logic [CNT_W:0]    rem_sh;
  logic [CNT_W:0]    rem_nx;
  logic              ge;
  logic [DUTY_W-1:0] quo_nx;
  logic              last_iter;

  // One restoring step: double the remainder and subtract the divisor if it fits.
  always_comb begin
    rem_sh = {rem_q[CNT_W-1:0], 1'b0};
    ge     = (rem_sh >= {1'b0, div_q});
    rem_nx = ge ? (rem_sh - {1'b0, div_q}) : rem_sh;
    quo_nx = (quo_q << 1) | DUTY_W'(ge);
  end

  assign last_iter = busy_q && (iter_q == LAST);
  assign busy      = busy_q;
  assign done      = last_iter;
  assign q         = sat_q ? {DUTY_W{1'b1}} : quo_nx;

  // Operand capture on start, then iterate until the last quotient bit.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      rem_q  <= '0;
      div_q  <= '0;
      quo_q  <= '0;
      iter_q <= '0;
      busy_q <= 1'b0;
      sat_q  <= 1'b0;
    end else if (start) begin
      rem_q  <= {1'b0, h};
      div_q  <= p;
      quo_q  <= '0;
      iter_q <= '0;
      busy_q <= 1'b1;
      sat_q  <= (h >= p);
    end else if (busy_q) begin
      rem_q  <= rem_nx;
      quo_q  <= quo_nx;
      iter_q <= iter_q + IW'(1);
      if (last_iter) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pwm_duty_meas.sv
// PWM receiver: measures period and high time of pwm_in in clk cycles and
// converts them into a DUTY_W-bit duty code.
module pwm_duty_meas
  import pwm_pkg::*;
#(
  parameter int DUTY_W      = DEF_DUTY_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty_out,
  output logic              duty_valid,
  output logic [CNT_W-1:0]  period_cnt,
  output logic [CNT_W-1:0]  high_cnt,
  output logic              timeout,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(timeout_count(CNT_W));

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_prev;
  logic                   rise;

  meas_state_t            state_q;
  meas_state_t            state_d;
  logic [CNT_W-1:0]       p_cnt;
  logic [CNT_W-1:0]       h_cnt;
  logic                   to_hit;

  logic                   restart;
  logic                   latch_meas;
  logic                   div_start;
  logic                   div_abort;
  logic                   do_timeout;
  logic                   publish;
  logic                   overrun_d;

  logic                   div_busy;
  logic                   div_done;
  logic [DUTY_W-1:0]      div_q;

  assign s      = sync_q[SYNC_STAGES-1];
  assign rise   = s & ~s_prev;
  assign to_hit = (p_cnt == TIMEOUT);

  // Input synchroniser chain plus the previous-sample flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_prev <= s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode; an edge always beats a timeout.
  always_comb begin
    state_d    = state_q;
    restart    = 1'b0;
    latch_meas = 1'b0;
    div_start  = 1'b0;
    div_abort  = 1'b0;
    do_timeout = 1'b0;
    publish    = 1'b0;
    overrun_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          restart = 1'b1;
          state_d = MEAS;
        end else if (to_hit) begin
          do_timeout = 1'b1;
        end
      end
      MEAS: begin
        if (rise) begin
          restart    = 1'b1;
          latch_meas = 1'b1;
          div_start  = 1'b1;
          state_d    = DIV;
        end else if (to_hit) begin
          do_timeout = 1'b1;
          state_d    = IDLE;
        end
      end
      DIV: begin
        if (rise) begin
          restart   = 1'b1;
          overrun_d = div_busy;
        end else if (to_hit) begin
          do_timeout = 1'b1;
          div_abort  = 1'b1;
          state_d    = IDLE;
        end
        if (div_done && !do_timeout) begin
          publish = 1'b1;
          state_d = MEAS;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Period/high counters; they also serve as the timeout counter in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_cnt <= '0;
      h_cnt <= '0;
    end else if (restart) begin
      p_cnt <= CNT_W'(1);
      h_cnt <= CNT_W'(1);
    end else if (do_timeout) begin
      p_cnt <= CNT_W'(1);
      h_cnt <= '0;
    end else begin
      p_cnt <= p_cnt + CNT_W'(1);
      h_cnt <= h_cnt + CNT_W'(s);
    end
  end

  pwm_div_seq #(
    .DUTY_W (DUTY_W),
    .CNT_W  (CNT_W)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .abort (div_abort),
    .h     (h_cnt),
    .p     (p_cnt),
    .busy  (div_busy),
    .done  (div_done),
    .q     (div_q)
  );

  // Registered outputs: measurement latch, duty publish and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_out   <= '0;
      duty_valid <= 1'b0;
      period_cnt <= '0;
      high_cnt   <= '0;
      timeout    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      timeout    <= 1'b0;
      overrun    <= overrun_d;
      if (latch_meas) begin
        period_cnt <= p_cnt;
        high_cnt   <= h_cnt;
      end
      if (publish) begin
        duty_out   <= div_q;
        duty_valid <= 1'b1;
      end
      if (do_timeout) begin
        timeout    <= 1'b1;
        duty_valid <= 1'b1;
        duty_out   <= s ? {DUTY_W{1'b1}} : '0;
        period_cnt <= '0;
        high_cnt   <= '0;
      end
    end
  end

endmodule
